// File: rtl/usb_protocol_ctrl.sv
// USB device-side transaction controller: sequences OUT/IN token handling, handshakes,
// DATA0/DATA1 toggle tracking and packet timeouts around an external receiver/transmitter.
module usb_protocol_ctrl #(
  parameter int unsigned TIMEOUT = 144
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] rx_pid_i,
  input  logic       rx_packet_done_i,
  input  logic       rx_error_i,
  input  logic       tx_done_i,
  input  logic [7:0] buffer_occupancy_i,
  input  logic       host_tx_req_i,
  input  logic       host_stall_i,
  output logic       tx_start_o,
  output logic [2:0] tx_packet_o,
  output logic       flush_o,
  output logic       rx_data_ready_o,
  output logic       tx_sent_o,
  output logic       xfer_error_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StSendHs,
    StWaitTxHs,
    StSendData,
    StWaitTxData,
    StWaitAck
  } state_e;

  localparam logic [2:0] PidOut   = 3'd1;
  localparam logic [2:0] PidIn    = 3'd2;
  localparam logic [2:0] PidData0 = 3'd3;
  localparam logic [2:0] PidData1 = 3'd4;
  localparam logic [2:0] PidAck   = 3'd5;

  localparam logic [2:0] PktNone  = 3'd0;
  localparam logic [2:0] PktData0 = 3'd1;
  localparam logic [2:0] PktData1 = 3'd2;
  localparam logic [2:0] PktAck   = 3'd3;
  localparam logic [2:0] PktNak   = 3'd4;
  localparam logic [2:0] PktStall = 3'd5;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic       rx_tog_q, tx_tog_q;
  logic [7:0] cnt_q;
  logic       tx_start_q, flush_q, rx_data_ready_q, tx_sent_q, xfer_error_q;
  logic [2:0] tx_packet_q;

  logic is_data, data_tog, timed_out;

  assign is_data   = (rx_pid_i == PidData0) || (rx_pid_i == PidData1);
  assign data_tog  = (rx_pid_i == PidData1);
  assign timed_out = (cnt_q == TimeoutLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      rx_tog_q        <= 1'b0;
      tx_tog_q        <= 1'b0;
      cnt_q           <= 8'd0;
      tx_start_q      <= 1'b0;
      tx_packet_q     <= PktNone;
      flush_q         <= 1'b0;
      rx_data_ready_q <= 1'b0;
      tx_sent_q       <= 1'b0;
      xfer_error_q    <= 1'b0;
    end else begin
      tx_start_q      <= 1'b0;
      flush_q         <= 1'b0;
      rx_data_ready_q <= 1'b0;
      tx_sent_q       <= 1'b0;
      xfer_error_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_packet_done_i) begin
            if (rx_error_i) begin
              flush_q <= 1'b1;
            end else if (rx_pid_i == PidOut) begin
              state_q <= StWaitData;
              cnt_q   <= 8'd0;
            end else if (rx_pid_i == PidIn) begin
              tx_start_q <= 1'b1;
              if (host_stall_i) begin
                tx_packet_q <= PktStall;
                state_q     <= StSendHs;
              end else if (host_tx_req_i && (buffer_occupancy_i != 8'd0)) begin
                tx_packet_q <= tx_tog_q ? PktData1 : PktData0;
                state_q     <= StSendData;
              end else begin
                tx_packet_q <= PktNak;
                state_q     <= StSendHs;
              end
            end
          end
        end
        StWaitData: begin
          cnt_q <= cnt_q + 8'd1;
          if (rx_packet_done_i) begin
            if (rx_error_i || !is_data) begin
              flush_q      <= 1'b1;
              xfer_error_q <= 1'b1;
              state_q      <= StIdle;
            end else begin
              tx_start_q <= 1'b1;
              state_q    <= StSendHs;
              if (host_stall_i) begin
                flush_q     <= 1'b1;
                tx_packet_q <= PktStall;
              end else if (data_tog == rx_tog_q) begin
                rx_tog_q        <= ~rx_tog_q;
                rx_data_ready_q <= 1'b1;
                tx_packet_q     <= PktAck;
              end else begin
                // Retransmission of a packet we already accepted: drop it but re-ACK.
                flush_q     <= 1'b1;
                tx_packet_q <= PktAck;
              end
            end
          end else if (timed_out) begin
            flush_q      <= 1'b1;
            xfer_error_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        StSendHs: begin
          state_q <= StWaitTxHs;
        end
        StSendData: begin
          state_q <= StWaitTxData;
        end
        StWaitTxHs: begin
          if (tx_done_i) begin
            tx_packet_q <= PktNone;
            state_q     <= StIdle;
          end
        end
        StWaitTxData: begin
          if (tx_done_i) begin
            tx_packet_q <= PktNone;
            cnt_q       <= 8'd0;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck: begin
          cnt_q <= cnt_q + 8'd1;
          if (rx_packet_done_i) begin
            if (!rx_error_i && (rx_pid_i == PidAck)) begin
              tx_tog_q  <= ~tx_tog_q;
              flush_q   <= 1'b1;
              tx_sent_q <= 1'b1;
            end else begin
              // Payload stays in the buffer so the host can retry the IN.
              xfer_error_q <= 1'b1;
            end
            state_q <= StIdle;
          end else if (timed_out) begin
            xfer_error_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx_start_o      = tx_start_q;
  assign tx_packet_o     = tx_packet_q;
  assign flush_o         = flush_q;
  assign rx_data_ready_o = rx_data_ready_q;
  assign tx_sent_o       = tx_sent_q;
  assign xfer_error_o    = xfer_error_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Randomized self-checking bench for usb_protocol_ctrl; a transaction-level model tracks the
// two data toggles and predicts the handshake, pulses and timing of each transaction.
module tb_usb_protocol_ctrl;

  localparam int unsigned TIMEOUT = 144;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_pid = 3'd0;
  logic       rx_packet_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] buffer_occupancy = 8'd0;
  logic       host_tx_req = 1'b0;
  logic       host_stall = 1'b0;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic       flush, rx_data_ready, tx_sent, xfer_error, busy;

  always #5 clk = ~clk;

  usb_protocol_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .rx_pid_i           (rx_pid),
    .rx_packet_done_i   (rx_packet_done),
    .rx_error_i         (rx_error),
    .tx_done_i          (tx_done),
    .buffer_occupancy_i (buffer_occupancy),
    .host_tx_req_i      (host_tx_req),
    .host_stall_i       (host_stall),
    .tx_start_o         (tx_start),
    .tx_packet_o        (tx_packet),
    .flush_o            (flush),
    .rx_data_ready_o    (rx_data_ready),
    .tx_sent_o          (tx_sent),
    .xfer_error_o       (xfer_error),
    .busy_o             (busy)
  );

  int checks = 0;
  int fails  = 0;

  // Pulse counters, sampled shortly after each rising edge.
  int n_flush = 0, n_rdy = 0, n_sent = 0, n_xerr = 0, n_start = 0, n_multi = 0;
  int s_flush, s_rdy, s_sent, s_xerr, s_start;

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (flush) n_flush++;
      if (rx_data_ready) n_rdy++;
      if (tx_sent) n_sent++;
      if (xfer_error) n_xerr++;
      if (tx_start) n_start++;
      if (int'(rx_data_ready) + int'(tx_sent) + int'(xfer_error) > 1) n_multi++;
    end
  end

  // Reference model state: expected OUT toggle and next IN toggle.
  bit m_rx_tog = 1'b0;
  bit m_tx_tog = 1'b0;

  task automatic snap();
    s_flush = n_flush; s_rdy = n_rdy; s_sent = n_sent; s_xerr = n_xerr; s_start = n_start;
  endtask

  function automatic logic [19:0] pulse_deltas();
    return {4'(n_flush - s_flush), 4'(n_rdy - s_rdy), 4'(n_sent - s_sent),
            4'(n_xerr - s_xerr), 4'(n_start - s_start)};
  endfunction

  task automatic send_pkt(input logic [2:0] pid, input logic err);
    @(negedge clk);
    rx_pid = pid; rx_error = err; rx_packet_done = 1'b1;
    @(negedge clk);
    rx_pid = 3'd0; rx_error = 1'b0; rx_packet_done = 1'b0;
  endtask

  // Waits (bounded) for tx_start, holds the transmitter busy a few cycles, then ends the packet.
  task automatic complete_tx(output logic [2:0] pkt, output bit held, output logic [2:0] after);
    pkt = 3'd0;
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tx_start) begin
        pkt = tx_packet;
        break;
      end
      @(negedge clk);
    end
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      if (tx_packet !== pkt) held = 1'b0;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    after = tx_packet;
  endtask

  task automatic run_out(input logic [2:0] dpid, input logic err, input logic stall,
                         input string tag);
    logic [2:0] pkt, after, e_pkt;
    logic [19:0] e_pulses;
    bit held;
    bit is_data = (dpid == 3'd3) || (dpid == 3'd4);
    bit tog = (dpid == 3'd4);
    int e_flush = 0, e_rdy = 0, e_xerr = 0;
    e_pkt = 3'd0;
    if (err || !is_data) begin
      e_flush = 1; e_xerr = 1;
    end else if (stall) begin
      e_flush = 1; e_pkt = 3'd5;
    end else if (tog == m_rx_tog) begin
      e_rdy = 1; e_pkt = 3'd3; m_rx_tog = !m_rx_tog;
    end else begin
      e_flush = 1; e_pkt = 3'd3;
    end
    host_stall = stall;
    snap();
    send_pkt(3'd1, 1'b0);
    send_pkt(dpid, err);
    checks++;
    if (busy !== (e_pkt != 3'd0)) begin
      fails++;
      $display("FAIL %s busy_after_data: got %b expected %b", tag, busy, e_pkt != 3'd0);
    end
    if (e_pkt == 3'd0) begin
      @(negedge clk);
    end else begin
      complete_tx(pkt, held, after);
      checks++;
      if (pkt !== e_pkt) begin
        fails++;
        $display("FAIL %s handshake: got %0d expected %0d", tag, pkt, e_pkt);
      end
      checks++;
      if (!held || after !== 3'd0) begin
        fails++;
        $display("FAIL %s tx_packet_hold: held %b, after tx_done %0d expected 0", tag, held, after);
      end
    end
    e_pulses = {4'(e_flush), 4'(e_rdy), 4'd0, 4'(e_xerr), 4'(e_pkt != 3'd0)};
    checks++;
    if (pulse_deltas() !== e_pulses) begin
      fails++;
      $display("FAIL %s pulses(flush,rdy,sent,xerr,start): got %h expected %h",
               tag, pulse_deltas(), e_pulses);
    end
    host_stall = 1'b0;
  endtask

  // resp: 0 clean ACK, 1 ACK with rx_error, 2 NAK, 3 no answer (timeout)
  task automatic run_in(input logic stall, input logic req, input logic [7:0] occ,
                        input int resp, input string tag);
    logic [2:0] pkt, after, e_pkt;
    logic [19:0] e_pulses;
    bit held;
    bit data;
    int cyc;
    int e_flush = 0, e_sent = 0, e_xerr = 0;
    data  = !stall && req && (occ != 8'd0);
    e_pkt = stall ? 3'd5 : (data ? (m_tx_tog ? 3'd2 : 3'd1) : 3'd4);
    host_stall = stall; host_tx_req = req; buffer_occupancy = occ;
    snap();
    send_pkt(3'd2, 1'b0);
    complete_tx(pkt, held, after);
    checks++;
    if (pkt !== e_pkt) begin
      fails++;
      $display("FAIL %s in_packet: got %0d expected %0d", tag, pkt, e_pkt);
    end
    checks++;
    if (!held || after !== 3'd0) begin
      fails++;
      $display("FAIL %s tx_packet_hold: held %b, after tx_done %0d expected 0", tag, held, after);
    end
    if (data) begin
      if (resp == 0) begin
        send_pkt(3'd5, 1'b0);
        e_flush = 1; e_sent = 1; m_tx_tog = !m_tx_tog;
      end else if (resp == 1) begin
        send_pkt(3'd5, 1'b1);
        e_xerr = 1;
      end else if (resp == 2) begin
        send_pkt(3'd6, 1'b0);
        e_xerr = 1;
      end else begin
        e_xerr = 1;
        cyc = 0;
        while (cyc < int'(TIMEOUT) + 20) begin
          @(negedge clk);
          cyc++;
          if (xfer_error) break;
        end
        checks++;
        if (cyc != int'(TIMEOUT)) begin
          fails++;
          $display("FAIL %s ack_timeout_cycle: got %0d expected %0d", tag, cyc, TIMEOUT);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_end: got %b expected 0", tag, busy);
    end
    e_pulses = {4'(e_flush), 4'd0, 4'(e_sent), 4'(e_xerr), 4'd1};
    checks++;
    if (pulse_deltas() !== e_pulses) begin
      fails++;
      $display("FAIL %s pulses(flush,rdy,sent,xerr,start): got %h expected %h",
               tag, pulse_deltas(), e_pulses);
    end
    host_stall = 1'b0; host_tx_req = 1'b0; buffer_occupancy = 8'd0;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    #1;
    outs = {tx_start, tx_packet, flush, rx_data_ready, tx_sent, xfer_error, busy};
    checks++;
    if (outs !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    outs = {tx_start, tx_packet, flush, rx_data_ready, tx_sent, xfer_error, busy};
    checks++;
    if (outs !== 9'd0) begin
      fails++;
      $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_out_toggle();
    run_out(3'd3, 1'b0, 1'b0, "out_data0");
    run_out(3'd3, 1'b0, 1'b0, "out_retry");
    run_out(3'd4, 1'b0, 1'b0, "out_data1");
    run_out(3'd3, 1'b0, 1'b1, "out_stall");
  endtask

  task automatic test_in_toggle();
    run_in(1'b0, 1'b1, 8'd4, 0, "in_data0");
    run_in(1'b0, 1'b1, 8'd4, 0, "in_data1");
  endtask

  task automatic test_in_timeout();
    run_in(1'b0, 1'b1, 8'd4, 3, "in_timeout");
    run_in(1'b0, 1'b1, 8'd4, 0, "in_resend");
    run_in(1'b0, 1'b1, 8'd9, 2, "in_nak_reply");
    run_in(1'b0, 1'b1, 8'd9, 1, "in_ack_err");
  endtask

  task automatic test_nak_stall();
    run_in(1'b0, 1'b0, 8'd4, 0, "nak_no_req");
    run_in(1'b0, 1'b1, 8'd0, 0, "nak_empty");
    run_in(1'b1, 1'b1, 8'd4, 0, "stall_full");
    run_in(1'b1, 1'b0, 8'd0, 0, "stall_empty");
  endtask

  task automatic test_out_error();
    run_out(3'd4, 1'b1, 1'b0, "out_rx_error");
    run_out(3'd5, 1'b0, 1'b0, "out_non_data");
    run_out(3'd1, 1'b0, 1'b1, "out_token_stall");
  endtask

  task automatic test_out_timeout();
    int cyc = 0;
    snap();
    send_pkt(3'd1, 1'b0);
    while (cyc < int'(TIMEOUT) + 20) begin
      @(negedge clk);
      cyc++;
      if (xfer_error) break;
    end
    checks++;
    if (cyc != int'(TIMEOUT)) begin
      fails++;
      $display("FAIL data_timeout_cycle: got %0d expected %0d", cyc, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({pulse_deltas(), busy} !== {20'h10010, 1'b0}) begin
      fails++;
      $display("FAIL data_timeout_pulses_busy: got %h expected %h",
               {pulse_deltas(), busy}, {20'h10010, 1'b0});
    end
  endtask

  task automatic test_ignored();
    snap();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    send_pkt(3'd3, 1'b0);
    send_pkt(3'd5, 1'b0);
    send_pkt(3'd0, 1'b0);
    send_pkt(3'd1, 1'b1);
    send_pkt(3'd2, 1'b1);
    @(negedge clk);
    checks++;
    if ({pulse_deltas(), busy} !== {20'h20000, 1'b0}) begin
      fails++;
      $display("FAIL idle_ignored: got %h expected %h", {pulse_deltas(), busy}, {20'h20000, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [2:0] dpid;
    int r;
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 9);
        dpid = (r < 4) ? 3'd3 : ((r < 8) ? 3'd4 : 3'($urandom_range(0, 7)));
        run_out(dpid, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, "rand_out");
      end else begin
        run_in($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
               ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2)), "rand_in");
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] outs;
    logic [2:0] pkt, after;
    bit held;
    if (!m_tx_tog) run_in(1'b0, 1'b1, 8'd4, 0, "pre_in");
    if (!m_rx_tog) run_out(3'd3, 1'b0, 1'b0, "pre_out");
    // Reset while a DATA1 packet is on the wire.
    host_tx_req = 1'b1; buffer_occupancy = 8'd4;
    send_pkt(3'd2, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    outs = {tx_start, tx_packet, flush, rx_data_ready, tx_sent, xfer_error, busy};
    checks++;
    if (outs !== 9'd0) begin
      fails++;
      $display("FAIL reset_in_wait_tx: got %h expected 0", outs);
    end
    m_rx_tog = 1'b0; m_tx_tog = 1'b0;
    @(negedge clk);
    // Token presented in the same cycle reset is released.
    rst = 1'b0;
    rx_pid = 3'd2; rx_packet_done = 1'b1;
    @(negedge clk);
    rx_pid = 3'd0; rx_packet_done = 1'b0;
    checks++;
    if ({tx_start, tx_packet} !== {1'b1, 3'd1}) begin
      fails++;
      $display("FAIL first_token_after_reset: got %h expected %h", {tx_start, tx_packet}, 4'h9);
    end
    complete_tx(pkt, held, after);
    #1 rst = 1'b1;
    #1;
    outs = {tx_start, tx_packet, flush, rx_data_ready, tx_sent, xfer_error, busy};
    checks++;
    if (outs !== 9'd0) begin
      fails++;
      $display("FAIL reset_in_wait_ack: got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    host_tx_req = 1'b0; buffer_occupancy = 8'd0;
    run_out(3'd3, 1'b0, 1'b0, "post_rst_out");
    run_in(1'b0, 1'b1, 8'd4, 0, "post_rst_in");
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_multi !== 0) begin
      fails++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_out_toggle();
    test_in_toggle();
    test_in_timeout();
    test_nak_stall();
    test_out_error();
    test_out_timeout();
    test_ignored();
    test_random();
    test_reset_mid();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_protocol_ctrl.md
USB_PROTOCOL_CTRL -- requirements
Module: usb_protocol_ctrl

Interface
REQ-001 Parameter TIMEOUT, 144, clock cycles allowed for an awaited packet (18 bit times at 8 clk/bit).
REQ-002 clk  in  1  single system clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 rx_pid  in  3  decoded receiver PID: 0 invalid, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL.
REQ-005 rx_packet_done  in  1  one-cycle pulse at receiver EOP; rx_pid and rx_error are valid in that cycle.
REQ-006 rx_error  in  1  receiver error flag for the finished packet.
REQ-007 tx_done  in  1  one-cycle pulse when the transmitter finishes a packet.
REQ-008 buffer_occupancy  in  8  data buffer byte count.
REQ-009 host_tx_req  in  1  host has IN data staged in the buffer.
REQ-010 host_stall  in  1  endpoint halted.
REQ-011 tx_start  out  1  one-cycle pulse that launches tx_packet.
REQ-012 tx_packet  out  3  0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; held from tx_start until tx_done.
REQ-013 flush  out  1  one-cycle buffer clear pulse.
REQ-014 rx_data_ready  out  1  one-cycle pulse: new OUT payload accepted.
REQ-015 tx_sent  out  1  one-cycle pulse: IN payload acknowledged by host.
REQ-016 xfer_error  out  1  one-cycle pulse on failed transaction.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States SHALL be IDLE, WAIT_DATA, SEND_HS, WAIT_TX_HS, SEND_DATA, WAIT_TX_DATA, WAIT_ACK; outputs are registered.
REQ-019 Two toggle bits SHALL be kept: rx_tog (expected OUT DATA PID) and tx_tog (next IN DATA PID), 0 = DATA0.
REQ-020 IDLE: rx_packet_done with rx_error SHALL pulse flush and stay IDLE; with rx_pid OUT SHALL go WAIT_DATA; with IN SHALL choose STALL if host_stall, else DATA(tx_tog) via SEND_DATA if host_tx_req and buffer_occupancy != 0, else NAK; any other PID SHALL be ignored.
REQ-021 WAIT_DATA: DATA PID matching rx_tog with no error SHALL flip rx_tog, pulse rx_data_ready, and send ACK; non-matching DATA PID (retry) SHALL pulse flush and send ACK with rx_tog unchanged; host_stall SHALL override both with flush plus STALL.
REQ-022 WAIT_DATA: rx_error, non-DATA PID, or TIMEOUT expiry SHALL pulse flush and xfer_error and return to IDLE with no handshake.
REQ-023 SEND_HS/SEND_DATA SHALL last one cycle asserting tx_start, then move to WAIT_TX_HS/WAIT_TX_DATA; tx_packet SHALL return to 0 in the cycle after tx_done.
REQ-024 WAIT_TX_HS on tx_done SHALL go IDLE; WAIT_TX_DATA on tx_done SHALL go WAIT_ACK and restart the timeout counter.
REQ-025 WAIT_ACK: error-free ACK SHALL flip tx_tog, pulse flush and tx_sent, go IDLE; any other packet, rx_error, or timeout SHALL pulse xfer_error, keep tx_tog and buffer contents, go IDLE.
REQ-026 Timeout counter SHALL be 8 bits, cleared on entry to WAIT_DATA/WAIT_ACK, expiring when it equals TIMEOUT-1; rx_packet_done in the expiry cycle SHALL take priority over the timeout.
REQ-027 rx_packet_done during SEND_*/WAIT_TX_* SHALL be ignored; tx_done outside WAIT_TX_* SHALL be ignored.
REQ-028 At most one of rx_data_ready, tx_sent, xfer_error SHALL pulse in any cycle.

Reset
REQ-029 rst SHALL immediately force state IDLE, rx_tog = tx_tog = 0, timeout counter 0, and all outputs 0, including a mid-transaction reset.
REQ-030 After rst deasserts, the first valid token SHALL be processed with no extra latency.

Verification
REQ-031 OUT, then DATA0 error-free -> one rx_data_ready pulse, tx_packet = 3 (ACK) with tx_start, rx_tog = 1; repeated DATA0 -> flush plus ACK, no rx_data_ready.
REQ-032 IN with host_tx_req = 1, occupancy = 4 -> tx_packet = 1; after tx_done, ACK -> tx_sent plus flush, next IN sends tx_packet = 2.
REQ-033 IN with no ACK for 144 cycles after tx_done -> xfer_error at cycle 144, tx_tog unchanged, next IN resends DATA0.
REQ-034 IN with host_tx_req = 0 -> NAK (4); with host_stall = 1 -> STALL (5), regardless of occupancy.
REQ-035 OUT followed by DATA1 with rx_error = 1 -> flush plus xfer_error, no tx_start, busy = 0 next cycle.
REQ-036 rst asserted in WAIT_ACK -> all outputs 0 and state IDLE immediately; toggles read back 0 on the next transaction.
